// File: rtl/dff_bist_pkg.sv
// Shared types and the phase table for the Dff_ flip-flop BIST.
package dff_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = 3;

    // Each entry is {sync, r, s, d, exp}; exp is the settled q for the phase (r > s > d).
    localparam logic [4:0] PHASE_TABLE [NUM_PHASES] = '{
        5'b0_0_0_0_0,
        5'b0_0_1_0_1,
        5'b0_1_1_0_0,
        5'b0_0_0_1_1,
        5'b1_1_0_1_0,
        5'b1_0_0_0_0,
        5'b1_0_1_0_1,
        5'b0_1_0_1_0
    };

    // Drive fields {sync, r, s, d} of a table entry.
    function automatic logic [3:0] phase_drive(input logic [4:0] entry);
        return entry[4:1];
    endfunction

endpackage

// File: rtl/dff_bist_checker.sv
// Compares the sampled DUT q against the golden value for the current phase edge.
module dff_bist_checker
    import dff_bist_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic               i_active,
    input  logic [PHASE_W-1:0] i_phase,
    input  logic [CNT_W-1:0]   i_cnt,
    input  logic               i_prev_exp,
    input  logic               i_dut_q,
    output logic               o_mismatch
);

    logic [4:0] w_entry;
    logic       w_sync;
    logic       w_force;
    logic       w_exp;

    assign w_entry = PHASE_TABLE[i_phase];
    assign w_sync  = w_entry[4];
    assign w_force = w_entry[3] | w_entry[2];
    assign w_exp   = w_entry[0];

    // cnt==0 is edge 1 of the phase: only forced changes are checked there, async must
    // already show the new value and sync must still show the old one.
    always_comb begin
        o_mismatch = 1'b0;
        if (i_active) begin
            if (i_cnt == '0) begin
                if (w_force && (w_exp != i_prev_exp)) begin
                    o_mismatch = (i_dut_q != (w_sync ? i_prev_exp : w_exp));
                end
            end else begin
                o_mismatch = (i_dut_q != w_exp);
            end
        end
    end

endmodule

// File: rtl/dff_bist.sv
// Sequencer for the Dff_ BIST: steps through eight phases and accumulates mismatches.
module dff_bist
    import dff_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_r,
    input  logic             i_start,
    input  logic             i_dut_q,
    output logic             o_dut_sync,
    output logic             o_dut_r,
    output logic             o_dut_s,
    output logic             o_dut_d,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count,
    output logic [2:0]       o_fail_phase
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_drive;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err_count;
    logic [2:0]         r_fail_phase;

    logic               w_prev_exp;
    logic               w_mismatch;
    logic [4:0]         w_prev_entry;

    assign w_prev_entry = PHASE_TABLE[r_phase - PHASE_W'(1)];
    assign w_prev_exp   = (r_phase == '0) ? 1'b0 : w_prev_entry[0];

    dff_bist_checker #(
        .CNT_W (CNT_W)
    ) u_checker (
        .i_active   (r_state == RUN),
        .i_phase    (r_phase),
        .i_cnt      (r_cnt),
        .i_prev_exp (w_prev_exp),
        .i_dut_q    (i_dut_q),
        .o_mismatch (w_mismatch)
    );

    // Control FSM with registered DUT drives and result outputs.
    always_ff @(posedge i_clk or posedge i_r) begin
        if (i_r) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_cnt        <= '0;
            r_drive      <= phase_drive(PHASE_TABLE[0]);
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_phase <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state      <= RUN;
                        r_phase      <= '0;
                        r_cnt        <= '0;
                        r_drive      <= phase_drive(PHASE_TABLE[0]);
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_fail_phase <= '0;
                    end
                end
                RUN: begin
                    if (w_mismatch) begin
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + ERR_W'(1);
                        end
                        if (r_err_count == '0) begin
                            r_fail_phase <= r_phase;
                        end
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_phase == PHASE_W'(NUM_PHASES - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_phase <= r_phase + PHASE_W'(1);
                            r_drive <= phase_drive(PHASE_TABLE[r_phase + PHASE_W'(1)]);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_pass  <= (r_err_count == '0);
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign {o_dut_sync, o_dut_r, o_dut_s, o_dut_d} = r_drive;
    assign o_busy       = (r_state == RUN);
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err_count;
    assign o_fail_phase = r_fail_phase;

endmodule

// File: tb/tb_dff_bist.sv
// Bench for dff_bist: behavioural flip-flop variants plus a phase-rule reference model.
module tb_dff_bist;

    localparam int HOLD  = 10;
    localparam int ERR_W = 8;
    localparam int RUN_N = 8 * HOLD;

    logic             clk = 1'b0;
    logic             r_in;
    logic             start;
    logic             dut_q;
    logic             dut_sync, dut_r, dut_s, dut_d;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       fail_phase;

    int checks = 0;
    int errors = 0;

    // Phase table restated as drives {sync,r,s,d} and settled q.
    logic [3:0] drv   [8] = '{4'b0000, 4'b0010, 4'b0110, 4'b0001,
                              4'b1101, 4'b1000, 4'b1010, 4'b0101};
    logic       exp_q [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Flip-flop under test: 0 correct, 1 stuck-at-0, 2 always sync, 3 always async,
    // 4 correct with random single-cycle output flips.
    int   mode = 0;
    logic m_q_reg = 1'b0;
    logic m_flip  = 1'b0;
    logic m_async;

    logic q_tr [RUN_N];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m_q_reg <= dut_r ? 1'b0 : (dut_s ? 1'b1 : dut_d);
        m_flip  <= (mode == 4) && ($urandom_range(0, 11) == 0);
    end

    always_comb begin
        m_async = ~dut_sync;
        if (mode == 2) m_async = 1'b0;
        if (mode == 3) m_async = 1'b1;
        if (mode == 1) dut_q = 1'b0;
        else dut_q = ((m_async & dut_r) ? 1'b0 : ((m_async & dut_s) ? 1'b1 : m_q_reg)) ^ m_flip;
    end

    dff_bist #(
        .HOLD_CYCLES (HOLD),
        .ERR_W       (ERR_W)
    ) u_dut (
        .i_clk        (clk),
        .i_r          (r_in),
        .i_start      (start),
        .i_dut_q      (dut_q),
        .o_dut_sync   (dut_sync),
        .o_dut_r      (dut_r),
        .o_dut_s      (dut_s),
        .o_dut_d      (dut_d),
        .o_busy       (busy),
        .o_done       (done),
        .o_pass       (pass),
        .o_err_count  (err_count),
        .o_fail_phase (fail_phase)
    );

    // Expected error count and first failing phase over the first n sampled edges.
    function automatic void ref_model(input int n, output int ne, output int fp);
        ne = 0;
        fp = 0;
        for (int i = 0; i < n; i++) begin
            int   p    = i / HOLD;
            int   k    = i % HOLD + 1;
            logic pv   = (p == 0) ? 1'b0 : exp_q[p-1];
            logic want = exp_q[p];
            logic chk  = 1'b1;
            if (k == 1) begin
                chk = (drv[p][2] | drv[p][1]) && (exp_q[p] != pv);
                if (drv[p][3]) want = pv;
            end
            if (chk && (q_tr[i] !== want)) begin
                if (ne == 0) fp = p;
                ne++;
            end
        end
        if (ne > 255) ne = 255;
    endfunction

    // One full run; samples taken 1 time unit after each edge, i counts edges after accept.
    task automatic do_run(input int m, input int pa, input int pb, input int cerr,
                          input int cfail);
        int ne, fp;
        mode = m;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i <= RUN_N + 2; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            start = (i == pa) || (i == pb);
            if (i < RUN_N) begin
                q_tr[i] = dut_q;
                checks++;
                if (busy !== 1'b1 || {dut_sync, dut_r, dut_s, dut_d} !== drv[i/HOLD]) begin
                    errors++;
                    $display("FAIL drive i=%0d busy=%b drv=%b want busy=1 drv=%b", i, busy,
                             {dut_sync, dut_r, dut_s, dut_d}, drv[i/HOLD]);
                end
            end else begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_end i=%0d got %b want 0", i, busy);
                end
            end
            checks++;
            if (done !== (i == RUN_N + 1)) begin
                errors++;
                $display("FAIL done i=%0d got %b want %b", i, done, (i == RUN_N + 1));
            end
            if (i == RUN_N + 1) begin
                ref_model(RUN_N, ne, fp);
                checks++;
                if (err_count !== ERR_W'(ne) || fail_phase !== 3'(fp) || pass !== (ne == 0))
                begin
                    errors++;
                    $display("FAIL result mode=%0d got err=%0d fp=%0d pass=%b want %0d %0d %b",
                             m, err_count, fail_phase, pass, ne, fp, (ne == 0));
                end
                if (cerr >= 0) begin
                    checks++;
                    if (err_count !== ERR_W'(cerr) || fail_phase !== 3'(cfail)) begin
                        errors++;
                        $display("FAIL plan mode=%0d got err=%0d fp=%0d want %0d %0d", m,
                                 err_count, fail_phase, cerr, cfail);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        r_in  = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass, err_count, fail_phase, dut_sync, dut_r, dut_s, dut_d} !== '0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b pass=%b err=%0d fp=%0d drv=%b want zeros",
                     busy, done, pass, err_count, fail_phase, {dut_sync, dut_r, dut_s, dut_d});
        end
        r_in = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_correct();         do_run(0, -1, -1, 0, 0);  endtask
    task automatic test_stuck_zero();      do_run(1, -1, -1, 29, 1); endtask
    task automatic test_always_sync();     do_run(2, -1, -1, 3, 1);  endtask
    task automatic test_always_async();    do_run(3, -1, -1, 2, 4);  endtask
    task automatic test_ignored_start();   do_run(0, 10, 50, 0, 0);  endtask

    task automatic test_abort();
        int ne, fp;
        mode = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 35; i++) begin
            q_tr[i] = dut_q;
            @(posedge clk); #1;
        end
        ref_model(35, ne, fp);
        checks++;
        if (err_count !== ERR_W'(ne) || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun got err=%0d busy=%b want %0d 1", err_count, busy, ne);
        end
        r_in = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, err_count, fail_phase, dut_sync, dut_r, dut_s, dut_d} !== '0) begin
            errors++;
            $display("FAIL abort got busy=%b pass=%b err=%0d fp=%0d drv=%b want zeros", busy,
                     pass, err_count, fail_phase, {dut_sync, dut_r, dut_s, dut_d});
        end
        @(posedge clk); #1 r_in = 1'b0;
        do_run(0, -1, -1, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            do_run(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4,
                   int'($urandom_range(1, RUN_N)), int'($urandom_range(1, RUN_N)), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck_zero();
        test_always_sync();
        test_always_async();
        test_ignored_start();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
